pipe_stage_elastic: RTL and testbench

//  Parametrised elastic pipeline stage register for the five-stage MIPS core.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_sat_counter.sv | 23 ++
 rtl/pipe_stage_elastic.sv | 113 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding, default payload width
// and field offsets of the instruction and pc+4 within the payload.
package pipe_pkg;

  localparam int unsigned DATA_W_DEFAULT = 96;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Payload packing used by the stage boundaries; the stage itself never looks inside.
  localparam int unsigned INSTR_LSB = 0;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned PCA4_LSB  = INSTR_LSB + INSTR_W;
  localparam int unsigned PCA4_W    = 32;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Generic elastic pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and saturating bubble/stall counters.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter int unsigned SKID        = 1,
  parameter int unsigned CLR_PAYLOAD = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign out_fire  = out_valid & out_ready & ~stall;
  assign in_fire   = in_valid & in_ready;

  if (SKID != 0) begin : g_skid
    // Depends on the state register only, so no in/out combinational path.
    assign in_ready = ~Clr & (state_q != ST_FULL);
  end else begin : g_single
    assign in_ready = ~Clr & (~out_valid | out_fire);
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          // Only reachable with SKID=1; the single-register in_ready requires out_fire.
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      if (CLR_PAYLOAD != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= ST_EMPTY;
      if (CLR_PAYLOAD != 0) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .Clk(Clk),
    .Clr(Clr),
    .inc(~out_valid),
    .cnt(bubble_cnt)
  );

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .Clk(Clk),
    .Clr(Clr),
    .inc(out_valid & ~out_fire),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a SKID=1 instance and a SKID=0/CNT_W=4 instance, each checked
// against a bounded-FIFO reference model with saturating cycle counters.
module tb_pipe_stage_elastic;

  localparam int unsigned DW = 96;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr       [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [DW-1:0] in_data   [2];
  logic          stall     [2];
  logic          flush     [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [DW-1:0] out_data  [2];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned CW = (g == 0) ? 16 : 4;
    localparam int unsigned SK = (g == 0) ? 1 : 0;
    localparam int unsigned CAP = (SK != 0) ? 2 : 1;

    logic [CW-1:0] bub, stc;
    logic [DW-1:0] mq[$];
    int unsigned   mb, ms;

    pipe_stage_elastic #(
      .DATA_W(DW),
      .SKID(SK),
      .CLR_PAYLOAD(1),
      .CNT_W(CW)
    ) u_dut (
      .Clk(clk),
      .Clr(clr[g]),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .in_data(in_data[g]),
      .stall(stall[g]),
      .flush(flush[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data(out_data[g]),
      .bubble_cnt(bub),
      .stall_cnt(stc)
    );

    // Reference: a FIFO of capacity CAP; the head is what downstream must see.
    always @(negedge clk) begin
      int unsigned occ, smax;
      bit ev, er, ofire;
      if (mon_en) begin
        smax  = (1 << CW) - 1;
        occ   = mq.size();
        ev    = (occ > 0);
        ofire = ev && out_ready[g] && !stall[g];
        if (SK != 0) er = !clr[g] && (occ < CAP);
        else         er = !clr[g] && (!ev || ofire);
        chk($sformatf("i%0d_in_ready", g), in_ready[g], er);
        chk($sformatf("i%0d_out_valid", g), out_valid[g], ev);
        if (ev) chk($sformatf("i%0d_out_data", g), out_data[g], mq[0]);
        chk($sformatf("i%0d_bubble_cnt", g), bub, mb);
        chk($sformatf("i%0d_stall_cnt", g), stc, ms);
        if (clr[g]) begin
          mq.delete();
          mb = 0;
          ms = 0;
        end else begin
          if (!ev && mb < smax) mb++;
          if (ev && !ofire && ms < smax) ms++;
          if (flush[g]) begin
            mq.delete();
          end else begin
            if (ofire) void'(mq.pop_front());
            if (in_valid[g] && er) mq.push_back(in_data[g]);
          end
        end
      end
    end
  end

  task automatic drive(input int g, input bit v, input logic [DW-1:0] d, input bit ordy,
                       input bit st, input bit fl);
    in_valid[g]  = v;
    in_data[g]   = d;
    out_ready[g] = ordy;
    stall[g]     = st;
    flush[g]     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      clr[g]       = 1'b1;
      in_valid[g]  = 1'b1;
      in_data[g]   = rnd();
      out_ready[g] = 1'b1;
      stall[g]     = 1'b0;
      flush[g]     = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      clr[g]      = 1'b0;
      in_valid[g] = 1'b0;
    end

    // Back-to-back stream 0x1..0x8
    for (int i = 1; i <= 8; i++) drive(0, 1, DW'(i), 1, 0, 0);
    repeat (3) drive(0, 0, '0, 1, 0, 0);

    // Backpressure: A into main, B into skid, C held until space frees
    drive(0, 1, DW'('hA), 0, 0, 0);
    drive(0, 1, DW'('hB), 0, 0, 0);
    repeat (3) drive(0, 1, DW'('hC), 0, 0, 0);
    repeat (2) drive(0, 1, DW'('hC), 1, 0, 0);
    repeat (4) drive(0, 0, '0, 1, 0, 0);

    // Stall while FULL, then flush together with stall and an arriving beat
    drive(0, 1, DW'('hD), 0, 0, 0);
    drive(0, 1, DW'('hE), 0, 0, 0);
    repeat (4) drive(0, 0, '0, 1, 1, 0);
    drive(0, 1, DW'('hF), 1, 1, 1);
    chk("flush_out_valid", out_valid[0], 1'b0);
    chk("flush_out_data", out_data[0], '0);
    repeat (3) drive(0, 0, '0, 1, 0, 0);

    // Second instance has been idle since reset: counter pinned at 15
    chk("sat_bubble_cnt", g_inst[1].bub, 4'd15);
    clr[1] = 1'b1;
    @(posedge clk);
    #1;
    clr[1] = 1'b0;
    chk("sat_bubble_clr", g_inst[1].bub, 4'd0);

    // Single register with out_ready toggling
    for (int i = 0; i < 8; i++) drive(1, 1, DW'('h100 + i), (i % 2) == 0, 0, 0);
    repeat (3) drive(1, 0, '0, 1, 0, 0);

    // Randomised traffic on both instances
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 300; i++) begin
        drive(g, $urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 30) == 0);
      end
      repeat (4) drive(g, 0, '0, 1, 0, 0);
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
